// File: rtl/seq_divider_if.sv
// Request/response channel bundle for the sequential divider.
// Latency: none, wires only. Backpressure: in_ready/out_ready valid-ready on each side.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; SEQ_DIVIDER_EARLY_OUT_EN adds |a|<|b| bypass.
// Latency: WIDTH+1 cycles accept-to-valid, 1 cycle for special cases (and early-out when enabled).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave dif
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH-1:0] result, result_nxt;
    logic             is_rem, is_rem_nxt;
    logic             sign_q, sign_q_nxt;
    logic             sign_r, sign_r_nxt;

    // Request decode
    logic             op_none, op_signed, op_rem;
    logic             a_neg, b_neg, b_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_none   = (dif.in_op == 3'd0) || (dif.in_op > 3'd4);
    assign op_signed = (dif.in_op == 3'd1) || (dif.in_op == 3'd3);
    assign op_rem    = (dif.in_op == 3'd3) || (dif.in_op == 3'd4);
    assign a_neg     = op_signed && dif.in_a[WIDTH-1];
    assign b_neg     = op_signed && dif.in_b[WIDTH-1];
    assign a_mag     = a_neg ? -dif.in_a : dif.in_a;
    assign b_mag     = b_neg ? -dif.in_b : dif.in_b;
    assign b_zero    = (dif.in_b == '0);
    assign ovf       = op_signed && (dif.in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&dif.in_b);

    // One restoring step; trial sign bit tells whether the divisor fits
    logic [WIDTH:0]   rem_sh, trial;
    logic             trial_neg;
    logic [WIDTH-1:0] rem_it, quo_it, q_fix, r_fix;

    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, dvs};
    assign trial_neg = trial[WIDTH];
    assign rem_it    = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_it    = {quo[WIDTH-2:0], ~trial_neg};
    assign q_fix     = sign_q ? -quo_it : quo_it;
    assign r_fix     = sign_r ? -rem_it : rem_it;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem;
        quo_nxt    = quo;
        dvs_nxt    = dvs;
        result_nxt = result;
        is_rem_nxt = is_rem;
        sign_q_nxt = sign_q;
        sign_r_nxt = sign_r;
        case (state)
            IDLE: begin
                if (dif.in_valid) begin
                    is_rem_nxt = op_rem;
                    sign_q_nxt = a_neg ^ b_neg;
                    sign_r_nxt = a_neg;
                    dvs_nxt    = b_mag;
                    if (op_none) begin
                        result_nxt = '0;
                        state_nxt  = DONE;
                    end else if (b_zero) begin
                        result_nxt = op_rem ? dif.in_a : '1;
                        state_nxt  = DONE;
                    end else if (ovf) begin
                        result_nxt = op_rem ? '0 : dif.in_a;
                        state_nxt  = DONE;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                    end else if (a_mag < b_mag) begin
                        // Raw dividend already carries the remainder's sign
                        result_nxt = op_rem ? dif.in_a : '0;
                        state_nxt  = DONE;
`endif
                    end else begin
                        cnt_nxt   = CNT_W'(WIDTH);
                        rem_nxt   = '0;
                        quo_nxt   = a_mag;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                rem_nxt = rem_it;
                quo_nxt = quo_it;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    result_nxt = is_rem ? r_fix : q_fix;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (dif.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            result <= '0;
            is_rem <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            dvs    <= dvs_nxt;
            result <= result_nxt;
            is_rem <= is_rem_nxt;
            sign_q <= sign_q_nxt;
            sign_r <= sign_r_nxt;
        end
    end

    assign dif.in_ready   = (state == IDLE);
    assign dif.out_valid  = (state == DONE);
    assign dif.out_result = result;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded random + directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider_if #(.WIDTH(32)) dif ();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        bit  ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd1: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            3'd4: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit          sgn;
        logic [31:0] ma, mb;
        sgn = (op == 3'd1) || (op == 3'd3);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (op == 3'd0 || op > 3'd4 || b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return (ma >= 0) && (mb >= 0) ? 33 : 33;
    endfunction

    // Monitor: pops the scoreboard on every response handshake
    bit          prev_valid = 1'b0;
    bit          prev_hs    = 1'b0;
    logic [31:0] prev_res   = '0;
    int          rise_cyc   = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (dif.out_valid && !prev_valid) rise_cyc = cyc;
            if (dif.out_valid && prev_valid && !prev_hs)
                chk(dif.out_result == prev_res, "result_hold", dif.out_result, prev_res);
            if (exp_q.size() > 0 && cyc > acc_q[0])
                chk(dif.in_ready == 1'b0, "busy_in_ready", 32'(dif.in_ready), 32'd0);
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", dif.out_result, 32'h0);
                end else begin
                    logic [31:0] e;
                    int          l, a;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    chk(dif.out_result == e, "result", dif.out_result, e);
                    chk(rise_cyc - a == l, "latency", 32'(rise_cyc - a), 32'(l));
                end
            end
            prev_valid = dif.out_valid;
            prev_res   = dif.out_result;
            prev_hs    = dif.out_valid && dif.out_ready;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        @(posedge clk); #1;
        dif.in_valid = 1'b1;
        dif.in_op    = op;
        dif.in_a     = a;
        dif.in_b     = b;
        @(negedge clk);
        while (!dif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!dif.in_ready) begin
            chk(1'b0, "accept_timeout", 32'(dif.in_ready), 32'd1);
        end else begin
            exp_q.push_back(ref_res(op, a, b));
            lat_q.push_back(ref_lat(op, a, b));
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        dif.in_a     = $urandom;
        dif.in_b     = $urandom;
        dif.in_op    = 3'($urandom);
    endtask

    task automatic wait_done(input bit rnd_bp);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rnd_bp) dif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        dif.out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            chk(1'b0, "response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          t;
        dif.in_valid  = 1'b0;
        dif.in_a      = '0;
        dif.in_b      = '0;
        dif.in_op     = '0;
        dif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(dif.in_ready == 1'b1, "reset_in_ready", 32'(dif.in_ready), 32'd1);
        chk(dif.out_valid == 1'b0, "reset_out_valid", 32'(dif.out_valid), 32'd0);
        chk(dif.out_result == 32'h0, "reset_out_result", dif.out_result, 32'h0);

        // Directed cases
        run_op(3'd2, 32'd100, 32'd7);
        run_op(3'd1, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'd7, 32'hFFFF_FFFE);
        run_op(3'd2, 32'd5, 32'd0);
        run_op(3'd3, 32'd5, 32'd0);
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFD, 32'd10);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd10);
        run_op(3'd0, 32'd55, 32'd5);
        run_op(3'd6, 32'd55, 32'd5);

        // Backpressure: hold out_ready low for 20 cycles after out_valid
        dif.out_ready = 1'b0;
        issue(3'd2, 32'd1000, 32'd10);
        t = 0;
        while (!dif.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(dif.out_valid == 1'b1, "bp_valid_rise", 32'(dif.out_valid), 32'd1);
        repeat (20) @(negedge clk);
        chk(dif.out_valid == 1'b1, "bp_valid_held", 32'(dif.out_valid), 32'd1);
        chk(dif.out_result == 32'd100, "bp_result_held", dif.out_result, 32'd100);
        chk(dif.in_ready == 1'b0, "bp_in_ready_low", 32'(dif.in_ready), 32'd0);
        @(posedge clk); #1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        chk(dif.in_ready == 1'b0, "bp_no_same_cycle", 32'(dif.in_ready), 32'd0);
        @(negedge clk);
        chk(dif.in_ready == 1'b1, "bp_in_ready_back", 32'(dif.in_ready), 32'd1);
        wait_done(1'b0);

        // Reset in the middle of CALC discards the operation
        issue(3'd1, 32'd1000, 32'd3);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(dif.in_ready == 1'b1, "midreset_in_ready", 32'(dif.in_ready), 32'd1);
        chk(dif.out_valid == 1'b0, "midreset_out_valid", 32'(dif.out_valid), 32'd0);
        chk(dif.out_result == 32'h0, "midreset_out_result", dif.out_result, 32'h0);
        run_op(3'd2, 32'd9, 32'd3);

        // Random operations with random response backpressure
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 40);
                2:       a = -$urandom_range(0, 40);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            issue(op, a, b);
            wait_done(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops. It is the sequential unit downstream of the ALU.
- It accepts one operand pair plus op through a valid/ready request channel. It returns one 32-bit result through a valid/ready response channel.
- One operation is in flight at a time. Division by zero and signed overflow are resolved as fast-path special cases.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- in_a  input  WIDTH  dividend.
- in_b  input  WIDTH  divisor.
- in_op  input  3  op encoding: 0=NONE, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5-7 are treated as NONE.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  quotient or remainder, per op.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0, internal regs=0.
- States: IDLE, CALC, DONE.
- Outputs are Moore-style:
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
  - out_result is registered and stable for the whole of DONE.
- IDLE: on in_valid&&in_ready (accept edge, cycle 0), latch op, the raw dividend, and the operand magnitudes.
  - Signed ops: magnitude = two's-complement abs. Record sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Unsigned ops: magnitudes are the raw values and both signs are 0.
  - Special cases are decided on the accept edge, go straight to DONE, and give out_valid at cycle 1:
    - NONE: result 0.
    - b==0: DIV/DIVU -> all ones; REM/REMU -> in_a unchanged.
    - DIV with a=0x80000000 and b=0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
  - Otherwise: counter=WIDTH, remainder=0, quotient=|a|, go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1.
  - trial = rem_shifted - |b|, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial and quo[0]=1. Else keep rem_shifted and set quo[0]=0.
  - counter decrements each cycle.
  - On the iteration where counter==1, apply sign fixup combinationally and register the selected result:
    - quotient negated if sign_q;
    - remainder negated if sign_r;
    - then go to DONE.
- Latency for a normal op: accept at cycle 0; CALC occupies cycles 1..WIDTH; out_valid rises at cycle WIDTH+1 (33 for the default).
- DONE: hold out_valid and out_result until out_valid&&out_ready, then go to IDLE.
  - in_ready returns the following cycle. There is no same-cycle re-accept.
- Backpressure: out_ready low keeps DONE for an unbounded time with no result change. in_valid is ignored outside IDLE.
- Operand changes on in_a/in_b after the accept edge have no effect.
- Reset asserted in any state, including mid-CALC, returns to IDLE with the reset values on the next edge. The partial result is discarded.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: on the accept edge of a non-special op with |a| < |b| (unsigned magnitude compare), skip CALC and go to DONE in 1 cycle.
  - Quotient = 0.
  - Remainder = raw in_a, which already carries the correct sign.
- Undefined: every non-special op takes the full WIDTH+1 cycle latency. The compare logic is absent.

Test Plan:
- DIVU a=100, b=7, out_ready=1 -> out_result=14, out_valid rises exactly 33 cycles after accept, in_ready low during cycles 1..33.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REMU a=7, b=0xFFFFFFFE -> 7.
- DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 1. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DIVU a=1000, b=10 with out_ready held low 20 cycles after out_valid -> out_valid and out_result=100 stable throughout; in_ready asserts the cycle after out_ready is raised.
- Accept DIV a=1000, b=3, assert rst at cycle 10 for one cycle -> next cycle in_ready=1, out_valid=0, out_result=0. A fresh DIVU a=9, b=3 then yields 3.
- With SEQ_DIVIDER_EARLY_OUT_EN defined: REM a=-3, b=10 -> 0xFFFFFFFD at cycle 1, DIV of the same operands -> 0. Without the macro, the same results arrive at cycle 33.
